id_ex_stage_reg: RTL and testbench
==================================

// Module: id_ex_stage_reg
// PURPOSE
//  ID->EX pipeline register for the 5-stage MIPS core. Captures the register file's reg1/reg2
//  read data plus decoded control and immediate at each rising edge. Owns load-use hazard
//  detection: inserts one bubble and tells IF/ID to hold. Also supports freeze and flush,
//  and keeps a saturating count of hazard bubbles.
// PARAMETERS
//  WORD_W     32  data/PC/immediate width
//  REG_ADDR_W  5  register index width
//  EXE_CMD_W   4  ALU command width
//  CNT_W      16  stall counter width
// PORTS
//  clk          in   1           pipeline clock, rising edge
//  rst          in   1           reset, asynchronous, active-high
//  freeze       in   1           hold all state (memory wait)
//  flush        in   1           squash the instruction entering EX (taken branch)
//  id_valid     in   1           ID holds a real instruction
//  id_pc        in   WORD_W      PC of ID instruction
//  id_reg1      in   WORD_W      register file read port 1 data
//  id_reg2      in   WORD_W      register file read port 2 data
//  id_imm       in   WORD_W      sign-extended immediate
//  id_src1      in   REG_ADDR_W  rs index, also drives register file src1
//  id_src2      in   REG_ADDR_W  rt index, also drives register file src2
//  id_src1_used in   1           instruction reads src1
//  id_src2_used in   1           instruction reads src2
//  id_dest      in   REG_ADDR_W  destination index
//  id_exe_cmd   in   EXE_CMD_W   ALU command
//  id_wb_en     in   1           write-back enable
//  id_mem_r_en  in   1           load
//  id_mem_w_en  in   1           store
//  ex_valid, ex_pc, ex_reg1, ex_reg2, ex_imm, ex_src1, ex_src2, ex_dest, ex_exe_cmd,
//  ex_wb_en, ex_mem_r_en, ex_mem_w_en  out  (matching id_* widths)  registered EX copies
//  hazard_stall out  1           combinational: IF/ID must hold this cycle
//  stall_count  out  CNT_W       number of hazard bubbles inserted
// BEHAVIOUR
//  Reset: every ex_* output and stall_count is 0 asynchronously on rst=1. The register stays
//   there until the first rising edge with rst=0. Reset mid-stall drops the pending bubble;
//   hazard_stall is 0 while in reset.
//  hazard_stall = id_valid & ex_valid & ex_mem_r_en & (ex_dest!=0) &
//   ((id_src1_used & id_src1==ex_dest) | (id_src2_used & id_src2==ex_dest)). Purely
//   combinational from the current ex_* state and id_* inputs.
//  Rising-edge update, priority high->low:
//   1 flush: ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en and ex_exe_cmd are 0. Data fields
//     are 0. Flush beats freeze and hazard.
//   2 freeze: all ex_* hold. stall_count holds.
//   3 hazard_stall: bubble, same clearing as flush. stall_count +1, saturating at all-ones.
//   4 otherwise: load all id_* into ex_*.
//  Latency: exactly 1 cycle ID->EX. A load-use pair costs exactly 1 bubble, because after the
//   bubble ex_mem_r_en is 0 and hazard_stall drops.
//  The register file writes on the falling edge. A WB write in the same cycle is therefore
//   already visible on id_reg1/id_reg2 at capture, so no WB->ID bypass exists here.
//  Destination 0: passed through unchanged. It never triggers a hazard.
//  id_valid=0: loads as a bubble (ex_valid=0, controls passed as given) and never stalls.
// TESTING
//  rst=1 mid-run -> all ex_* and stall_count 0 immediately, before any clock edge.
//  lw $5 then add $6,$5,$7 (src1_used) -> hazard_stall=1 for 1 cycle; next EX ex_valid=0,
//   ex_mem_r_en=0; the cycle after, EX holds the add; stall_count=1.
//  lw $0 then use $0, or lw $5 then an instr with src2=5 but src2_used=0 -> no stall.
//  freeze=1 for 3 cycles with ID changing -> ex_* identical to pre-freeze values; stall_count
//   unchanged.
//  flush=1 together with freeze=1 and a live hazard -> bubble; stall_count unchanged.
//  Force 2^CNT_W+2 load-use pairs (or preload via hierarchy) -> stall_count saturates at
//   16'hFFFF.

Source files
------------

// File: rtl/id_ex_stage_reg_if.sv
// ID->EX stage bundle: decoded ID fields in, registered EX copies out.
// Also carries freeze/flush control plus hazard and stall-count status.
interface id_ex_stage_reg_if #(
  parameter int WORD_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int EXE_CMD_W  = 4,
  parameter int CNT_W      = 16
);
  logic                  freeze;
  logic                  flush;
  logic                  id_valid;
  logic [WORD_W-1:0]     id_pc;
  logic [WORD_W-1:0]     id_reg1;
  logic [WORD_W-1:0]     id_reg2;
  logic [WORD_W-1:0]     id_imm;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic                  id_src1_used;
  logic                  id_src2_used;
  logic [REG_ADDR_W-1:0] id_dest;
  logic [EXE_CMD_W-1:0]  id_exe_cmd;
  logic                  id_wb_en;
  logic                  id_mem_r_en;
  logic                  id_mem_w_en;

  logic                  ex_valid;
  logic [WORD_W-1:0]     ex_pc;
  logic [WORD_W-1:0]     ex_reg1;
  logic [WORD_W-1:0]     ex_reg2;
  logic [WORD_W-1:0]     ex_imm;
  logic [REG_ADDR_W-1:0] ex_src1;
  logic [REG_ADDR_W-1:0] ex_src2;
  logic [REG_ADDR_W-1:0] ex_dest;
  logic [EXE_CMD_W-1:0]  ex_exe_cmd;
  logic                  ex_wb_en;
  logic                  ex_mem_r_en;
  logic                  ex_mem_w_en;
  logic                  hazard_stall;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output freeze, flush, id_valid, id_pc,
    output id_reg1, id_reg2, id_imm,
    output id_src1, id_src2,
    output id_src1_used, id_src2_used,
    output id_dest, id_exe_cmd, id_wb_en,
    output id_mem_r_en, id_mem_w_en,
    input  ex_valid, ex_pc, ex_reg1,
    input  ex_reg2, ex_imm, ex_src1,
    input  ex_src2, ex_dest, ex_exe_cmd,
    input  ex_wb_en, ex_mem_r_en, ex_mem_w_en,
    input  hazard_stall, stall_count
  );

  modport slave (
    input  freeze, flush, id_valid, id_pc,
    input  id_reg1, id_reg2, id_imm,
    input  id_src1, id_src2,
    input  id_src1_used, id_src2_used,
    input  id_dest, id_exe_cmd, id_wb_en,
    input  id_mem_r_en, id_mem_w_en,
    output ex_valid, ex_pc, ex_reg1,
    output ex_reg2, ex_imm, ex_src1,
    output ex_src2, ex_dest, ex_exe_cmd,
    output ex_wb_en, ex_mem_r_en, ex_mem_w_en,
    output hazard_stall, stall_count
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register with load-use bubble insertion,
// freeze/flush handling and a saturating hazard-bubble counter.
module id_ex_stage_reg #(
  parameter int WORD_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int EXE_CMD_W  = 4,
  parameter int CNT_W      = 16
) (
  input logic               clk,
  input logic               rst,
  id_ex_stage_reg_if.slave  bus
);
  typedef struct packed {
    logic                  valid;
    logic [WORD_W-1:0]     pc;
    logic [WORD_W-1:0]     reg1;
    logic [WORD_W-1:0]     reg2;
    logic [WORD_W-1:0]     imm;
    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
    logic [REG_ADDR_W-1:0] dest;
    logic [EXE_CMD_W-1:0]  exe_cmd;
    logic                  wb_en;
    logic                  mem_r_en;
    logic                  mem_w_en;
  } ex_t;

  ex_t              ex_q, ex_d, id_in;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hz;
  logic             hit1, hit2;

  // Load-use detect against the load now sitting in EX.
  always_comb begin
    hit1 = bus.id_src1_used
         & (bus.id_src1 == ex_q.dest);
    hit2 = bus.id_src2_used
         & (bus.id_src2 == ex_q.dest);
    hz   = ~rst & bus.id_valid
         & ex_q.valid & ex_q.mem_r_en
         & (ex_q.dest != '0)
         & (hit1 | hit2);
  end

  // Next EX contents and counter, flush > freeze > hazard.
  always_comb begin
    id_in = '{
      valid:    bus.id_valid,
      pc:       bus.id_pc,
      reg1:     bus.id_reg1,
      reg2:     bus.id_reg2,
      imm:      bus.id_imm,
      src1:     bus.id_src1,
      src2:     bus.id_src2,
      dest:     bus.id_dest,
      exe_cmd:  bus.id_exe_cmd,
      wb_en:    bus.id_wb_en,
      mem_r_en: bus.id_mem_r_en,
      mem_w_en: bus.id_mem_w_en
    };
    ex_d  = ex_q;
    cnt_d = cnt_q;
    priority case (1'b1)
      bus.flush:  ex_d = '0;
      bus.freeze: ex_d = ex_q;
      hz: begin
        ex_d = '0;
        if (cnt_q != '1)
          cnt_d = cnt_q + 1'b1;
      end
      default:    ex_d = id_in;
    endcase
  end

  // State register; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_pc        = ex_q.pc;
  assign bus.ex_reg1      = ex_q.reg1;
  assign bus.ex_reg2      = ex_q.reg2;
  assign bus.ex_imm       = ex_q.imm;
  assign bus.ex_src1      = ex_q.src1;
  assign bus.ex_src2      = ex_q.src2;
  assign bus.ex_dest      = ex_q.dest;
  assign bus.ex_exe_cmd   = ex_q.exe_cmd;
  assign bus.ex_wb_en     = ex_q.wb_en;
  assign bus.ex_mem_r_en  = ex_q.mem_r_en;
  assign bus.ex_mem_w_en  = ex_q.mem_w_en;
  assign bus.hazard_stall = hz;
  assign bus.stall_count  = cnt_q;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: vector table plus
// hand sequences for async reset and counter saturation.
module tb_id_ex_stage_reg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg_if #(.CNT_W(16)) b ();
  id_ex_stage_reg_if #(.CNT_W(3))  s ();

  id_ex_stage_reg #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(b.slave)
  );
  id_ex_stage_reg #(.CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .bus(s.slave)
  );

  assign s.freeze       = b.freeze;
  assign s.flush        = b.flush;
  assign s.id_valid     = b.id_valid;
  assign s.id_pc        = b.id_pc;
  assign s.id_reg1      = b.id_reg1;
  assign s.id_reg2      = b.id_reg2;
  assign s.id_imm       = b.id_imm;
  assign s.id_src1      = b.id_src1;
  assign s.id_src2      = b.id_src2;
  assign s.id_src1_used = b.id_src1_used;
  assign s.id_src2_used = b.id_src2_used;
  assign s.id_dest      = b.id_dest;
  assign s.id_exe_cmd   = b.id_exe_cmd;
  assign s.id_wb_en     = b.id_wb_en;
  assign s.id_mem_r_en  = b.id_mem_r_en;
  assign s.id_mem_w_en  = b.id_mem_w_en;

  typedef enum { LOAD, BUB, HOLD } kind_e;

  typedef struct {
    logic fl, fz, v;
    logic [31:0] pc;
    logic [4:0] s1; logic s1u;
    logic [4:0] s2; logic s2u;
    logic [4:0] dst; logic rd;
    logic hz; kind_e k; int cnt;
  } vec_t;

  typedef struct {
    logic v; logic [31:0] pc, r1, r2, imm;
    logic [4:0] s1, s2, dst; logic [3:0] cmd;
    logic wb, rd, wr;
  } exp_t;

  exp_t last;

  task automatic chk(string n, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endtask

  function automatic exp_t mk(vec_t x);
    exp_t e;
    e.v = x.v; e.pc = x.pc;
    e.r1 = x.pc ^ 32'hA5A5_0000;
    e.r2 = ~x.pc; e.imm = x.pc << 1;
    e.s1 = x.s1; e.s2 = x.s2; e.dst = x.dst;
    e.cmd = x.pc[5:2]; e.wb = 1'b1;
    e.rd = x.rd; e.wr = x.pc[2];
    return e;
  endfunction

  task automatic drive(vec_t x);
    b.flush = x.fl; b.freeze = x.fz;
    b.id_valid = x.v; b.id_pc = x.pc;
    b.id_reg1 = x.pc ^ 32'hA5A5_0000;
    b.id_reg2 = ~x.pc; b.id_imm = x.pc << 1;
    b.id_src1 = x.s1; b.id_src1_used = x.s1u;
    b.id_src2 = x.s2; b.id_src2_used = x.s2u;
    b.id_dest = x.dst; b.id_exe_cmd = x.pc[5:2];
    b.id_wb_en = 1'b1; b.id_mem_r_en = x.rd;
    b.id_mem_w_en = x.pc[2];
  endtask

  task automatic chk_ex(string n, exp_t e);
    chk({n, ".v"},   b.ex_valid,    e.v);
    chk({n, ".pc"},  b.ex_pc,       e.pc);
    chk({n, ".r1"},  b.ex_reg1,     e.r1);
    chk({n, ".r2"},  b.ex_reg2,     e.r2);
    chk({n, ".imm"}, b.ex_imm,      e.imm);
    chk({n, ".s1"},  b.ex_src1,     e.s1);
    chk({n, ".s2"},  b.ex_src2,     e.s2);
    chk({n, ".dst"}, b.ex_dest,     e.dst);
    chk({n, ".cmd"}, b.ex_exe_cmd,  e.cmd);
    chk({n, ".wb"},  b.ex_wb_en,    e.wb);
    chk({n, ".rd"},  b.ex_mem_r_en, e.rd);
    chk({n, ".wr"},  b.ex_mem_w_en, e.wr);
  endtask

  function automatic vec_t V(
    logic fl, logic fz, logic v, logic [31:0] pc,
    logic [4:0] s1, logic s1u,
    logic [4:0] s2, logic s2u,
    logic [4:0] dst, logic rd,
    logic hz, kind_e k, int cnt);
    vec_t x;
    x.fl = fl; x.fz = fz; x.v = v; x.pc = pc;
    x.s1 = s1; x.s1u = s1u; x.s2 = s2; x.s2u = s2u;
    x.dst = dst; x.rd = rd;
    x.hz = hz; x.k = k; x.cnt = cnt;
    return x;
  endfunction

  vec_t tv[$];
  vec_t lw5, add, lwl;
  exp_t zero;

  initial begin
    zero = '{default: '0};
    last = zero;
    //       fl fz v  pc     s1 u  s2 u  dst rd hz k    cnt
    tv.push_back(V(0,0,1,32'h100, 1,1, 0,0, 5,1, 0,LOAD,0));
    tv.push_back(V(0,0,1,32'h104, 5,1, 7,1, 6,0, 1,BUB ,1));
    tv.push_back(V(0,0,1,32'h104, 5,1, 7,1, 6,0, 0,LOAD,1));
    tv.push_back(V(0,0,1,32'h108, 2,1, 0,0, 0,1, 0,LOAD,1));
    tv.push_back(V(0,0,1,32'h10c, 0,1, 0,1, 3,0, 0,LOAD,1));
    tv.push_back(V(0,0,1,32'h110, 1,1, 0,0, 5,1, 0,LOAD,1));
    tv.push_back(V(0,0,1,32'h114, 4,1, 5,0, 8,0, 0,LOAD,1));
    tv.push_back(V(0,0,1,32'h118, 1,1, 0,0, 9,1, 0,LOAD,1));
    tv.push_back(V(0,0,0,32'h11c, 9,1, 0,0,10,0, 0,LOAD,1));
    tv.push_back(V(0,0,1,32'h120, 1,1, 0,0, 9,1, 0,LOAD,1));
    tv.push_back(V(0,0,1,32'h124, 0,0, 9,1,11,0, 1,BUB ,2));
    tv.push_back(V(0,1,1,32'h124, 0,0, 9,1,11,0, 0,HOLD,2));
    tv.push_back(V(0,0,1,32'h124, 0,0, 9,1,11,0, 0,LOAD,2));
    tv.push_back(V(0,0,1,32'h128, 1,1, 0,0,12,1, 0,LOAD,2));
    tv.push_back(V(1,1,1,32'h12c,12,1, 0,0,13,0, 1,BUB ,2));
    tv.push_back(V(0,0,1,32'h130, 1,1, 0,0,12,1, 0,LOAD,2));
    tv.push_back(V(0,1,1,32'h134,12,1, 0,0,13,0, 1,HOLD,2));
    tv.push_back(V(0,1,1,32'h138,12,1, 0,0,14,0, 1,HOLD,2));
    tv.push_back(V(0,1,1,32'h13c, 3,1, 0,0,15,0, 0,HOLD,2));
    tv.push_back(V(0,0,1,32'h140,12,1, 0,0,16,0, 1,BUB ,3));
    tv.push_back(V(0,0,1,32'h140,12,1, 0,0,16,0, 0,LOAD,3));

    drive(V(0,0,0,0,0,0,0,0,0,0,0,LOAD,0));
    #2;
    chk("rst.cnt", b.stall_count, 0);
    chk("rst.hz",  b.hazard_stall, 0);
    chk_ex("rst", zero);
    @(negedge clk);
    rst = 1'b0;

    foreach (tv[i]) begin
      @(negedge clk);
      drive(tv[i]);
      #1;
      chk($sformatf("v%0d.hz", i), b.hazard_stall, tv[i].hz);
      @(posedge clk);
      #1;
      if (tv[i].k == LOAD) last = mk(tv[i]);
      else if (tv[i].k == BUB) last = zero;
      chk_ex($sformatf("v%0d", i), last);
      chk($sformatf("v%0d.cnt", i), b.stall_count, tv[i].cnt);
    end

    // async reset while a hazard is live
    lw5 = V(0,0,1,32'h150, 1,1, 0,0, 5,1, 0,LOAD,0);
    add = V(0,0,1,32'h154, 5,1, 7,1, 6,0, 0,LOAD,0);
    @(negedge clk);
    drive(lw5);
    @(posedge clk);
    @(negedge clk);
    drive(add);
    #1;
    chk("mr.hz_pre", b.hazard_stall, 1);
    rst = 1'b1;
    #1;
    chk("mr.hz", b.hazard_stall, 0);
    chk("mr.cnt", b.stall_count, 0);
    chk_ex("mr", zero);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_ex("mr.after", mk(add));
    chk("mr.cnt2", b.stall_count, 0);

    // repeated load-use on a self-dependent load
    lwl = V(0,0,1,32'h200, 5,1, 0,0, 5,1, 0,LOAD,0);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      drive(lwl);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk($sformatf("sat%0d.hz", n), b.hazard_stall, 1);
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d.v", n), b.ex_valid, 0);
      chk($sformatf("sat%0d.cnt", n), b.stall_count, n);
      chk($sformatf("sat%0d.cs", n), s.stall_count,
          (n > 7) ? 7 : n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
